// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF/MEM pipeline stages, the shared SRAM
// and the arbiter that multiplexes them.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              freeze_if;
    logic              freeze_pipe;
    logic              busy;

    modport slave (
        input  if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, sram_en, sram_we,
               sram_addr, sram_wdata, freeze_if, freeze_pipe, busy
    );

    modport master (
        output if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, sram_en, sram_we,
               sram_addr, sram_wdata, freeze_if, freeze_pipe, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter for the IF and MEM stages: MEM has strict priority,
// each grant runs WAIT_CYCLES access cycles followed by a one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4   // legal range 1..15 (4-bit counter)
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              owner_mem;
    logic              we;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              if_ready;
    logic              mem_ready;
    logic              busy;
    logic              mem_req;

    assign mem_req = bus.mem_rd_en | bus.mem_wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner_mem <= 1'b0;
            we        <= 1'b0;
            en        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        // rd+wr together resolves to a store
                        owner_mem <= 1'b1;
                        addr      <= bus.mem_addr;
                        wdata     <= bus.mem_wdata;
                        we        <= bus.mem_wr_en;
                        cnt       <= CNT_LOAD;
                        en        <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end else if (bus.if_req) begin
                        owner_mem <= 1'b0;
                        addr      <= bus.if_addr;
                        we        <= 1'b0;
                        cnt       <= CNT_LOAD;
                        en        <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!we) begin
                            if (owner_mem) mem_rdata <= bus.sram_rdata;
                            else           if_rdata  <= bus.sram_rdata;
                        end
                        en        <= 1'b0;
                        we        <= 1'b0;
                        if_ready  <= ~owner_mem;
                        mem_ready <= owner_mem;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    en    <= 1'b0;
                    we    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sram_en     = en;
    assign bus.sram_we     = we;
    assign bus.sram_addr   = addr;
    assign bus.sram_wdata  = wdata;
    assign bus.if_rdata    = if_rdata;
    assign bus.mem_rdata   = mem_rdata;
    assign bus.if_ready    = if_ready;
    assign bus.mem_ready   = mem_ready;
    assign bus.busy        = busy;
    // Fetch also stalls behind a MEM transfer since if_ready only fires for IF grants
    assign bus.freeze_if   = bus.if_req & ~if_ready;
    assign bus.freeze_pipe = mem_req & ~mem_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected (data, ready-cycle) pairs, monitors
// pop and compare on every ready pulse. Two instances cover WAIT_CYCLES=4 and 1.
module tb_mem_port_arbiter;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;

    exp_t if_q[$];
    exp_t mem_q[$];
    exp_t b_q[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ia ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ia));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ib));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model for instance A: preloaded table, writes land on the clock edge
    logic [31:0] mem_a [0:1023];
    bit          mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= 32'h0;
            mem_a[4]   <= 32'hE3A0_1005;
            mem_a[8]   <= 32'hA5A5_0001;
            mem_a[256] <= 32'h1234_5678;
            mem_loaded <= 1'b1;
        end else if (ia.sram_en && ia.sram_we) begin
            mem_a[ia.sram_addr[11:2]] <= ia.sram_wdata;
        end
    end
    assign ia.sram_rdata = (ia.sram_en && !ia.sram_we) ? mem_a[ia.sram_addr[11:2]] : 32'h0;
    assign ib.sram_rdata = 32'hCAFE_0000 | {16'h0, ib.sram_addr[15:0]};

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void chk1(input string nm, input logic act, input logic exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitors: every ready pulse must match the oldest expectation for that port
    always @(negedge clk) begin
        exp_t e;
        if (ia.if_ready === 1'b1) begin
            if (if_q.size() == 0) chk1("a_if_ready_unexpected", 1'b1, 1'b0);
            else begin
                e = if_q.pop_front();
                chk("a_if_rdata", ia.if_rdata, e.data);
                chk("a_if_ready_cycle", cyc, e.cyc);
            end
        end
        if (ia.mem_ready === 1'b1) begin
            if (mem_q.size() == 0) chk1("a_mem_ready_unexpected", 1'b1, 1'b0);
            else begin
                e = mem_q.pop_front();
                chk("a_mem_rdata", ia.mem_rdata, e.data);
                chk("a_mem_ready_cycle", cyc, e.cyc);
            end
        end
        if (ib.if_ready === 1'b1) begin
            if (b_q.size() == 0) chk1("b_if_ready_unexpected", 1'b1, 1'b0);
            else begin
                e = b_q.pop_front();
                chk("b_if_rdata", ib.if_rdata, e.data);
                chk("b_if_ready_cycle", cyc, e.cyc);
            end
        end
        if (ib.mem_ready === 1'b1) chk1("b_mem_ready_unexpected", 1'b1, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold requests until their ready pulse, then drop them in the following cycle
    task automatic wait_done(input bit want_if, input bit want_mem);
        bit if_done  = !want_if;
        bit mem_done = !want_mem;
        for (int n = 0; n < 40 && !(if_done && mem_done); n++) begin
            @(negedge clk);
            if (ia.if_ready)  if_done  = 1'b1;
            if (ia.mem_ready) mem_done = 1'b1;
            tick();
            if (if_done)  ia.if_req = 1'b0;
            if (mem_done) begin
                ia.mem_rd_en = 1'b0;
                ia.mem_wr_en = 1'b0;
            end
        end
        if (!(if_done && mem_done)) chk1("wait_done_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        ia.if_req = 0; ia.if_addr = 0; ia.mem_rd_en = 0; ia.mem_wr_en = 0;
        ia.mem_addr = 0; ia.mem_wdata = 0;
        ib.if_req = 0; ib.if_addr = 0; ib.mem_rd_en = 0; ib.mem_wr_en = 0;
        ib.mem_addr = 0; ib.mem_wdata = 0;
        tick(); tick();
        @(negedge clk);
        chk1("rst_sram_en", ia.sram_en, 1'b0);
        chk1("rst_sram_we", ia.sram_we, 1'b0);
        chk("rst_sram_addr", ia.sram_addr, 32'h0);
        chk("rst_sram_wdata", ia.sram_wdata, 32'h0);
        chk1("rst_if_ready", ia.if_ready, 1'b0);
        chk1("rst_mem_ready", ia.mem_ready, 1'b0);
        chk("rst_if_rdata", ia.if_rdata, 32'h0);
        chk("rst_mem_rdata", ia.mem_rdata, 32'h0);
        chk1("rst_busy", ia.busy, 1'b0);
        chk1("rst_freeze_if", ia.freeze_if, 1'b0);
        chk1("rst_freeze_pipe", ia.freeze_pipe, 1'b0);
        chk1("rst_b_busy", ib.busy, 1'b0);
        tick();
        rst = 1'b0;

        // Single fetch: ACCESS t+1..t+4, ready at t+5
        t = cyc;
        ia.if_req = 1'b1; ia.if_addr = 32'h10;
        if_q.push_back('{32'hE3A0_1005, t + 5});
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk1("fetch_freeze_if", ia.freeze_if, k < 5);
            chk1("fetch_sram_en", ia.sram_en, k >= 1 && k <= 4);
            if (k >= 1 && k <= 4) chk("fetch_sram_addr", ia.sram_addr, 32'h10);
            if (k >= 1 && k <= 4) chk1("fetch_busy", ia.busy, 1'b1);
        end
        tick();
        ia.if_req = 1'b0;

        // Simultaneous IF + MEM load: MEM first, IF follows
        t = cyc;
        ia.if_req = 1'b1; ia.if_addr = 32'h20;
        ia.mem_rd_en = 1'b1; ia.mem_addr = 32'h400;
        mem_q.push_back('{32'h1234_5678, t + 5});
        if_q.push_back('{32'hA5A5_0001, t + 11});
        @(negedge clk);
        chk1("simul_freeze_if", ia.freeze_if, 1'b1);
        chk1("simul_freeze_pipe", ia.freeze_pipe, 1'b1);
        wait_done(1'b1, 1'b1);

        // Store: 4 write cycles, mem_rdata untouched, freeze_pipe drops at ready
        t = cyc;
        ia.mem_wr_en = 1'b1; ia.mem_addr = 32'h80; ia.mem_wdata = 32'hDEAD_BEEF;
        mem_q.push_back('{32'h1234_5678, t + 5});
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk1("store_freeze_pipe", ia.freeze_pipe, k < 5);
            if (k >= 1 && k <= 4) begin
                chk1("store_sram_en", ia.sram_en, 1'b1);
                chk1("store_sram_we", ia.sram_we, 1'b1);
                chk("store_sram_addr", ia.sram_addr, 32'h80);
                chk("store_sram_wdata", ia.sram_wdata, 32'hDEAD_BEEF);
            end
        end
        tick();
        ia.mem_wr_en = 1'b0;

        // Load back what was stored
        t = cyc;
        ia.mem_rd_en = 1'b1; ia.mem_addr = 32'h80;
        mem_q.push_back('{32'hDEAD_BEEF, t + 5});
        wait_done(1'b0, 1'b1);

        // Reset in the 2nd ACCESS cycle aborts the fetch and clears rdata
        ia.if_req = 1'b1; ia.if_addr = 32'h10;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ia.if_req = 1'b0;
        @(negedge clk);
        chk1("abort_busy", ia.busy, 1'b0);
        chk1("abort_sram_en", ia.sram_en, 1'b0);
        chk("abort_if_rdata", ia.if_rdata, 32'h0);
        chk("abort_mem_rdata", ia.mem_rdata, 32'h0);
        repeat (8) tick();
        t = cyc;
        ia.if_req = 1'b1; ia.if_addr = 32'h10;
        if_q.push_back('{32'hE3A0_1005, t + 5});
        wait_done(1'b1, 1'b0);

        // Load dropped mid-access still completes on schedule
        t = cyc;
        ia.mem_rd_en = 1'b1; ia.mem_addr = 32'h400;
        mem_q.push_back('{32'h1234_5678, t + 5});
        tick(); tick();
        ia.mem_rd_en = 1'b0;
        @(negedge clk);
        chk1("drop_freeze_pipe", ia.freeze_pipe, 1'b0);
        repeat (5) tick();

        // rd+wr together is a store: mem_rdata keeps the last load value
        t = cyc;
        ia.mem_rd_en = 1'b1; ia.mem_wr_en = 1'b1;
        ia.mem_addr = 32'h84; ia.mem_wdata = 32'h0BAD_F00D;
        mem_q.push_back('{32'h1234_5678, t + 5});
        tick();
        @(negedge clk);
        chk1("rdwr_sram_we", ia.sram_we, 1'b1);
        wait_done(1'b0, 1'b1);
        t = cyc;
        ia.mem_rd_en = 1'b1; ia.mem_addr = 32'h84;
        mem_q.push_back('{32'h0BAD_F00D, t + 5});
        wait_done(1'b0, 1'b1);

        // WAIT_CYCLES=1 with held if_req: ready every 3 cycles
        t = cyc;
        ib.if_req = 1'b1; ib.if_addr = 32'h10;
        for (int i = 0; i < 4; i++) b_q.push_back('{32'hCAFE_0010, t + 2 + 3 * i});
        repeat (12) tick();
        ib.if_req = 1'b0;

        repeat (4) tick();
        chk("if_q_drained", if_q.size(), 32'd0);
        chk("mem_q_drained", mem_q.size(), 32'd0);
        chk("b_q_drained", b_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency SRAM between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage ARM pipeline.
- Accepts level-held requests from both stages and grants one at a time through a small FSM with a wait-state counter.
- Returns read data with a one-cycle ready pulse to the winning requester.
- Produces freeze signals that stall IF_Stage/IF_Stage_Reg and the downstream stage registers while an access is outstanding.

Parameters:
- ADDR_W, 32, address width of both requesters and SRAM.
- DATA_W, 32, data width.
- WAIT_CYCLES, 4, SRAM access cycles per transfer; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid when if_ready=1
- if_ready  out  1  one-cycle completion pulse for IF
- mem_rd_en  in  1  MEM load request, held until mem_ready
- mem_wr_en  in  1  MEM store request, held until mem_ready
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid when mem_ready=1
- mem_ready  out  1  one-cycle completion pulse for MEM
- sram_en  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid in the last access cycle
- freeze_if  out  1  stall IF stage and IF register
- freeze_pipe  out  1  stall ID/EXE/MEM/WB stage registers
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: state=IDLE; counter=0; owner=IF.
  - All outputs are 0 on reset, including latched addr/wdata and the rdata registers.
  - Reset mid-access aborts the transfer: no ready pulse, sram_en=0 from the next edge.
- States:
  - IDLE: sample requests.
    - Any MEM request (mem_rd_en|mem_wr_en): latch owner=MEM, addr, wdata, we=mem_wr_en.
    - Else if_req: latch owner=IF, addr=if_addr, we=0.
    - Load counter=WAIT_CYCLES-1 and go to ACCESS. No request: stay.
  - ACCESS: drive sram_en=1, sram_we=latched we, sram_addr/sram_wdata from latches.
    - Counter>0: decrement, stay.
    - Counter==0: on a read, capture sram_rdata into the owner's rdata register; go to DONE.
  - DONE: sram_en=0. Pulse the owner's ready for exactly one cycle; next state IDLE.
- Latency:
  - Request seen in IDLE at cycle t gives ready at cycle t+WAIT_CYCLES+1.
  - Next IDLE sample at t+WAIT_CYCLES+2. Minimum inter-grant spacing is WAIT_CYCLES+2 cycles.
- Priority:
  - MEM strictly over IF; the older instruction must drain.
  - A simultaneous IF request stays pending and is granted at the next IDLE if still asserted.
- Inputs sampled only in IDLE. Changes to addr/wdata/req during ACCESS/DONE are ignored.
  - A request dropped mid-access still completes and still pulses ready.
- mem_rd_en and mem_wr_en both high: treated as a write.
- rdata registers:
  - Hold their value until the next read by the same owner.
  - A write never changes mem_rdata.
- freeze_if = if_req & ~if_ready (combinational); a MEM transfer therefore also stalls fetch.
- freeze_pipe = (mem_rd_en|mem_wr_en) & ~mem_ready.
- No outputs are combinationally dependent on sram_rdata.

Test Plan:
- Reset, then a single fetch:
  - Stimulus: rst 2 cycles; if_req=1, if_addr=0x0000_0010 at t; SRAM returns 0xE3A0_1005.
  - Required: sram_en=1, sram_addr=0x10 for cycles t+1..t+4; if_ready=1 only at t+5; if_rdata=0xE3A0_1005; freeze_if high t..t+4.
- Simultaneous requests:
  - Stimulus: if_req=1 and mem_rd_en=1 (addr 0x400, data 0x1234_5678) at t.
  - Required: MEM granted first, mem_ready at t+5, mem_rdata=0x1234_5678; IF granted at t+6, if_ready at t+11.
- Store:
  - Stimulus: mem_wr_en=1, mem_addr=0x80, mem_wdata=0xDEAD_BEEF.
  - Required: sram_we=1 with those values for 4 cycles; mem_ready pulse; mem_rdata unchanged from previous value; freeze_pipe deasserts in the ready cycle.
- Reset mid-access:
  - Stimulus: assert rst in the 2nd ACCESS cycle.
  - Required: next cycle busy=0, sram_en=0, no ready pulse; a new request after reset completes normally.
- WAIT_CYCLES=1:
  - Stimulus: back-to-back held if_req.
  - Required: ready every 3 cycles.
- Request dropped:
  - Stimulus: mem_rd_en dropped mid-access.
  - Required: mem_ready still pulses at t+WAIT_CYCLES+1.
